// File: rtl/shift_add_mult4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_add_mult4_pkg                                              |
// | Shared width default and FSM state encoding for the multiplier.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package shift_add_mult4_pkg;

  localparam int MULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  // 2'd3 is unreachable and is treated as IDLE by the FSM.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/add4_csel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | add4_csel                                                        |
// | WIDTH-bit carry-select adder: ripple low half, duplicated upper  |
// | half (carry 0/1) selected by the low-half carry.  Rev 1.0        |
// +------------------------------------------------------------------+
module add4_csel
  import shift_add_mult4_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic [LO:0]   w_c_lo;
  logic [LO-1:0] w_s_lo;
  logic [HI:0]   w_c_h0;
  logic [HI:0]   w_c_h1;
  logic [HI-1:0] w_s_h0;
  logic [HI-1:0] w_s_h1;

  assign w_c_lo[0] = cin;
  assign w_c_h0[0] = 1'b0;
  assign w_c_h1[0] = 1'b1;

  for (genvar i = 0; i < LO; i++) begin : g_lo
    assign w_s_lo[i]   = a[i] ^ b[i] ^ w_c_lo[i];
    assign w_c_lo[i+1] = (a[i] & b[i]) | (w_c_lo[i] & (a[i] ^ b[i]));
  end

  for (genvar i = 0; i < HI; i++) begin : g_hi
    assign w_s_h0[i]   = a[LO+i] ^ b[LO+i] ^ w_c_h0[i];
    assign w_c_h0[i+1] = (a[LO+i] & b[LO+i]) | (w_c_h0[i] & (a[LO+i] ^ b[LO+i]));
    assign w_s_h1[i]   = a[LO+i] ^ b[LO+i] ^ w_c_h1[i];
    assign w_c_h1[i+1] = (a[LO+i] & b[LO+i]) | (w_c_h1[i] & (a[LO+i] ^ b[LO+i]));
  end

  assign sum  = {(w_c_lo[LO] ? w_s_h1 : w_s_h0), w_s_lo};
  assign cout = w_c_lo[LO] ? w_c_h1[HI] : w_c_h0[HI];

endmodule
`default_nettype wire

// File: rtl/shift_add_mult4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shift_add_mult4                                                  |
// | Radix-2 shift-and-add unsigned multiplier, WIDTH x WIDTH.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module shift_add_mult4
  import shift_add_mult4_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_p_next;

  assign w_addend = r_p[0] ? r_m : '0;

  add4_csel #(.WIDTH(WIDTH)) u_add (
    .a    (r_p[2*WIDTH-1:WIDTH]),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // The adder carry becomes the new MSB as the partial product shifts right.
  assign w_p_next = {w_cout, w_sum, r_p[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_m       <= '0;
      r_p       <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_p <= w_p_next;
          if (r_cnt == CNT_LAST) begin
            r_product <= w_p_next;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          // IDLE, DONE and the unused encoding all accept a new request.
          if (start) begin
            r_m     <= a;
            r_p     <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule
`default_nettype wire
